// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: frame assembler that sits behind the UART byte receiver.
// Hunts for a sync byte, then collects the length, payload and checksum bytes.
// Only a complete, checksum-correct frame is offered to the consumer. A
// malformed or stalled frame is dropped and reported through frame_err/err_code.
//
// Consumer handshake (frame_valid / frame_ack):
//   - frame_valid rises one cycle after the checksum byte arrives.
//   - While frame_valid is high, the buffer and frame_len are frozen.
//   - frame_valid stays high until frame_ack is seen high on a clock edge.
//     On that edge frame_valid falls and hunting for the next sync byte restarts.
//   - frame_ack has no effect while frame_valid is low.
//   - While a frame is held, every byte that arrives is dropped and pulses overrun.
module serial_frame_ctrl #(
    parameter int                Width        = 8,
    parameter int                MaxLen       = 16,
    parameter int                TimeoutWidth = 16,
    parameter logic [Width-1:0]  Sync         = Width'(8'hA5),
    localparam int               AddrW        = (MaxLen > 1) ? $clog2(MaxLen) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [Width-1:0]  byte_in,
    input  logic              byte_done,
    output logic              frame_valid,
    output logic [Width-1:0]  frame_len,
    input  logic [AddrW-1:0]  rd_addr,
    output logic [Width-1:0]  rd_data,
    input  logic              frame_ack,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              overrun
);

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [Width-1:0]        MaxLenB   = Width'(MaxLen);
    localparam logic [TimeoutWidth-1:0] TimerMax  = '1;
    localparam logic [1:0]              ErrCsum   = 2'd1;
    localparam logic [1:0]              ErrLen    = 2'd2;
    localparam logic [1:0]              ErrTmo    = 2'd3;

    state_t                  state;
    logic                    byte_done_d;
    logic                    ev;
    logic [TimeoutWidth-1:0] timer;
    logic [TimeoutWidth-1:0] timer_next;
    logic [Width-1:0]        sum;
    logic [AddrW-1:0]        index;
    logic                    in_frame;
    logic                    last_payload;
    logic [Width-1:0]        mem [MaxLen];

    // Rising edge of byte_done marks exactly one new byte.
    assign ev         = byte_done & ~byte_done_d;
    assign timer_next = timer + TimeoutWidth'(1);
    assign in_frame   = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    // The current payload byte is the final one when index equals frame_len-1.
    assign last_payload = (Width'(index) == (frame_len - Width'(1)));
    assign rd_data    = mem[rd_addr];

    // Frame FSM: byte edge detection, inter-byte timeout, checksum and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            byte_done_d <= 1'b1;
            timer       <= '0;
            sum         <= '0;
            index       <= '0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
            overrun     <= 1'b0;
        end else begin
            byte_done_d <= byte_done;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;

            // Idle cycles inside a frame advance the timer. Reaching all-ones
            // abandons the frame. A byte in the same cycle takes priority.
            if (in_frame && !ev) begin
                if (timer_next == TimerMax) begin
                    frame_err <= 1'b1;
                    err_code  <= ErrTmo;
                    timer     <= '0;
                    state     <= HUNT;
                end else begin
                    timer <= timer_next;
                end
            end

            case (state)
                HUNT: begin
                    timer <= '0;
                    if (ev && (byte_in == Sync)) begin
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (ev) begin
                        timer <= '0;
                        if (byte_in > MaxLenB) begin
                            frame_err <= 1'b1;
                            err_code  <= ErrLen;
                            state     <= HUNT;
                        end else begin
                            frame_len <= byte_in;
                            sum       <= byte_in;
                            index     <= '0;
                            state     <= (byte_in == '0) ? CSUM : PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (ev) begin
                        timer <= '0;
                        sum   <= sum + byte_in;
                        index <= index + AddrW'(1);
                        if (last_payload) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (ev) begin
                        timer <= '0;
                        if (byte_in == sum) begin
                            frame_valid <= 1'b1;
                            state       <= DONE;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ErrCsum;
                            state     <= HUNT;
                        end
                    end
                end
                DONE: begin
                    timer <= '0;
                    if (ev) begin
                        overrun <= 1'b1;
                    end
                    if (frame_ack) begin
                        frame_valid <= 1'b0;
                        state       <= HUNT;
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

    // Payload buffer: written only by payload bytes. It is frozen while a frame is held.
    always_ff @(posedge clk) begin
        if (ev && (state == PAYLOAD)) begin
            mem[index] <= byte_in;
        end
    end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl. A frame-level reference model collects
// received bytes in a queue and judges each frame once it is complete. A
// compare process checks every DUT output against that model on each cycle.
// Literal expectations for the test-plan vectors pin the model itself.
module tb_serial_frame_ctrl;

    localparam int         W      = 8;
    localparam int         MAXLEN = 16;
    localparam int         TW     = 4;
    localparam int         AW     = 4;
    localparam int         TMAX   = (1 << TW) - 1;
    localparam logic [7:0] SYNC   = 8'hA5;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  byte_in = '0;
    logic          byte_done = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          frame_ack = 1'b0;
    logic          frame_valid;
    logic [W-1:0]  frame_len;
    logic [W-1:0]  rd_data;
    logic          frame_err;
    logic [1:0]    err_code;
    logic          overrun;

    always #5 clk = ~clk;

    serial_frame_ctrl #(
        .Width(W), .MaxLen(MAXLEN), .TimeoutWidth(TW), .Sync(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_done(byte_done),
        .frame_valid(frame_valid), .frame_len(frame_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_ack(frame_ack), .frame_err(frame_err),
        .err_code(err_code), .overrun(overrun)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int ovr_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic         m_prev_bd;
    logic [W-1:0] rx_q[$];     // bytes of the frame being collected (sync first)
    logic [W-1:0] exp_q[$];    // payload of the held frame
    bit           m_held;
    int           m_idle;
    logic         m_valid, m_err, m_ovr;
    logic [W-1:0] m_len;
    logic [1:0]   m_code;

    task automatic model_reset();
        m_prev_bd = 1'b1;
        rx_q.delete();
        m_held  = 0;
        m_idle  = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_ovr   = 1'b0;
        m_len   = '0;
        m_code  = 2'd0;
    endtask

    task automatic model_flag(input logic [1:0] code);
        m_err  = 1'b1;
        m_code = code;
        rx_q.delete();
        m_idle = 0;
    endtask

    task automatic model_step();
        logic         ev;
        logic [W-1:0] s;
        ev = byte_done && !m_prev_bd;
        m_prev_bd = byte_done;
        m_err = 1'b0;
        m_ovr = 1'b0;
        if (m_held) begin
            if (ev) m_ovr = 1'b1;
            if (frame_ack) begin
                m_held  = 0;
                m_valid = 1'b0;
            end
        end else if (rx_q.size() == 0) begin
            if (ev && byte_in == SYNC) begin
                rx_q.push_back(byte_in);
                m_idle = 0;
            end
        end else if (ev) begin
            m_idle = 0;
            rx_q.push_back(byte_in);
            if (rx_q.size() == 2) begin
                if (int'(byte_in) > MAXLEN) model_flag(2'd2);
                else m_len = byte_in;
            end else if (rx_q.size() == int'(rx_q[1]) + 3) begin
                s = '0;
                for (int i = 1; i < rx_q.size() - 1; i++) s = s + rx_q[i];
                if (s == rx_q[rx_q.size()-1]) begin
                    exp_q.delete();
                    for (int i = 2; i < rx_q.size() - 1; i++) exp_q.push_back(rx_q[i]);
                    m_held  = 1;
                    m_valid = 1'b1;
                    rx_q.delete();
                end else begin
                    model_flag(2'd1);
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TMAX) model_flag(2'd3);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- scoreboard: per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (frame_err === 1'b1) err_pulses++;
            if (overrun === 1'b1) ovr_pulses++;
            check("frame_valid", 32'(frame_valid), 32'(m_valid));
            check("frame_len", 32'(frame_len), 32'(m_len));
            check("frame_err", 32'(frame_err), 32'(m_err));
            check("err_code", 32'(err_code), 32'(m_code));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (m_valid && int'(rd_addr) < int'(m_len) && int'(rd_addr) < exp_q.size())
                check("rd_data", 32'(rd_data), 32'(exp_q[rd_addr]));
        end
    end

    // ---------------- driver tasks ----------------
    logic [W-1:0] seq[$];

    task automatic send_byte(input logic [W-1:0] b);
        byte_in   = b;
        byte_done = 1'b1;
        @(negedge clk);
        byte_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic check_rd(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
        rd_addr = a;
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    // ---------------- directed stimulus ----------------
    int e0;
    int o0;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);
        check("reset_valid", 32'(frame_valid), 32'h0);
        check("reset_code", 32'(err_code), 32'h0);

        // Good frame.
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_seq();
        check("good_valid", 32'(frame_valid), 32'h1);
        check("good_len", 32'(frame_len), 32'h3);
        check_rd("good_rd0", 4'd0, 8'h11);
        check_rd("good_rd1", 4'd1, 8'h22);
        check_rd("good_rd2", 4'd2, 8'h33);
        ack();
        check("good_ack", 32'(frame_valid), 32'h0);

        // Bad checksum, then a good frame.
        e0 = err_pulses;
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
        send_seq();
        check("csum_pulses", 32'(err_pulses - e0), 32'h1);
        check("csum_code", 32'(err_code), 32'h1);
        check("csum_valid", 32'(frame_valid), 32'h0);
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_seq();
        check("after_csum_valid", 32'(frame_valid), 32'h1);
        ack();

        // Length limit.
        e0 = err_pulses;
        seq = '{8'hA5, 8'h11};
        send_seq();
        check("len_pulses", 32'(err_pulses - e0), 32'h1);
        check("len_code", 32'(err_code), 32'h2);
        seq = '{8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) seq.push_back(8'(i * 7 + 1));
        seq.push_back(8'h68);
        send_seq();
        check("max_valid", 32'(frame_valid), 32'h1);
        check("max_len", 32'(frame_len), 32'h10);
        check_rd("max_rd15", 4'd15, 8'h6A);
        ack();

        // Leading garbage and zero-length frame; stray ack while hunting.
        seq = '{8'h00, 8'hFF, 8'h5A};
        send_seq();
        ack();
        seq = '{8'hA5, 8'h00, 8'h00};
        send_seq();
        check("zero_valid", 32'(frame_valid), 32'h1);
        check("zero_len", 32'(frame_len), 32'h0);
        ack();

        // Sync value inside the payload is plain data.
        seq = '{8'hA5, 8'h02, 8'hA5, 8'h01, 8'hA8};
        send_seq();
        check("sync_data_valid", 32'(frame_valid), 32'h1);
        check_rd("sync_data_rd0", 4'd0, 8'hA5);
        ack();

        // Timeout: 15 idle cycles after the last byte.
        e0 = err_pulses;
        seq = '{8'hA5, 8'h02, 8'h11};
        send_seq();
        idle(14);
        send_byte(8'h22);
        check("tmo_pulses", 32'(err_pulses - e0), 32'h1);
        check("tmo_code", 32'(err_code), 32'h3);
        check("tmo_valid", 32'(frame_valid), 32'h0);

        // A byte arriving on the last idle cycle wins over the timeout.
        e0 = err_pulses;
        send_seq();
        idle(13);
        send_byte(8'h22);
        send_byte(8'h35);
        check("edge_pulses", 32'(err_pulses - e0), 32'h0);
        check("edge_valid", 32'(frame_valid), 32'h1);
        ack();

        // Overrun while a frame is held; ack coinciding with a byte.
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_seq();
        o0 = ovr_pulses;
        send_byte(8'h77);
        check("ovr_pulses", 32'(ovr_pulses - o0), 32'h1);
        check("ovr_valid", 32'(frame_valid), 32'h1);
        check_rd("ovr_rd0", 4'd0, 8'h11);
        frame_ack = 1'b1;
        byte_in   = 8'h55;
        byte_done = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        byte_done = 1'b0;
        @(negedge clk);
        check("ack_ovr_pulses", 32'(ovr_pulses - o0), 32'h2);
        check("ack_ovr_valid", 32'(frame_valid), 32'h0);

        // Reset in the middle of a payload with byte_done held high.
        e0 = err_pulses;
        seq = '{8'hA5, 8'h04, 8'h11};
        send_seq();
        byte_in   = 8'h22;
        byte_done = 1'b1;
        rst       = 1'b1;
        #1;
        check("rst_code", 32'(err_code), 32'h0);
        check("rst_len", 32'(frame_len), 32'h0);
        idle(2);
        rst = 1'b0;
        idle(3);
        byte_done = 1'b0;
        idle(20);
        check("rst_pulses", 32'(err_pulses - e0), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        seq = '{8'hA5, 8'h01, 8'h42, 8'h43};
        send_seq();
        check("post_rst_valid", 32'(frame_valid), 32'h1);
        check_rd("post_rst_rd0", 4'd0, 8'h42);
        ack();

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
